mem_access: RTL

Memory-access stage of the five-stage core: consumes the EX/MA pipeline register (pc, rd, result, store data, cause, tval, load/store ops) and issues loads and stores on the data bus. Holds the pipeline via `stall_req` while a transaction is outstanding. Raises load/store misalignment exceptions. Formats load data with byte-lane selection and sign or zero extension, then registers everything into the MA/WB stage register.

---
 rtl/mem_access.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the five-stage core.
// Takes the EX/MA pipeline register, issues one load or store at a time on the
// 64-bit data bus, raises misalignment exceptions, formats load data, and
// registers the outcome into the MA/WB stage register.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   clear, stall, trap_en      flush MA/WB, global pipeline hold, trap this cycle
//   pc_in .. unsign            EX/MA register contents (address in result_in)
//   dbus_req/we/addr/wdata/wmask, dbus_ack, dbus_rdata   data bus
//   stall_req                  pipeline hold while a transaction is in flight
//   pc_out .. tval_out         MA/WB register
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        stall,
    input  logic        trap_en,
    input  logic [63:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [63:0] result_in,
    input  logic [63:0] data2_in,
    input  logic [4:0]  cause_in,
    input  logic [63:0] tval_in,
    input  logic        load,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [63:0] dbus_addr,
    output logic [63:0] dbus_wdata,
    output logic [7:0]  dbus_wmask,
    input  logic        dbus_ack,
    input  logic [63:0] dbus_rdata,
    output logic        stall_req,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] result_out,
    output logic [4:0]  cause_out,
    output logic [63:0] tval_out
);

    localparam int unsigned XLEN    = 64;
    localparam int unsigned CAUSE_W = 5;
    localparam int unsigned MASK_W  = 8;

    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = CAUSE_W'(4);
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = CAUSE_W'(6);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]         addr_lo;
    logic               aligned;
    logic               mem_op;
    logic               issue;
    logic [XLEN-1:0]    wdata_repl;
    logic [XLEN-1:0]    wdata_c;
    logic [MASK_W-1:0]  wmask_c;
    logic [CAUSE_W-1:0] exc_cause;
    logic [XLEN-1:0]    exc_tval;

    logic [2:0]         lane_q;
    logic [1:0]         size_q;
    logic               unsign_q;
    logic               is_store_q;
    logic               kill_q;
    logic [XLEN-1:0]    ld_data_q;
    logic [XLEN-1:0]    rdata_sh;
    logic [XLEN-1:0]    ld_fmt;

    assign addr_lo = result_in[2:0];

    // Alignment check against the access size
    always_comb begin
        aligned = 1'b1;
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (addr_lo[0] == 1'b0);
            2'd2:    aligned = (addr_lo[1:0] == 2'd0);
            default: aligned = (addr_lo == 3'd0);
        endcase
    end

    assign mem_op = (load | store) && (cause_in == CAUSE_W'(0)) && aligned;
    assign issue  = mem_op && !clear && !trap_en;

    // Store data replicated to fill the doubleword, then moved to its lane
    always_comb begin
        wdata_repl = data2_in;
        wmask_c    = 8'hFF;
        case (size)
            2'd0: begin
                wdata_repl = {8{data2_in[7:0]}};
                wmask_c    = MASK_W'(8'h01 << addr_lo);
            end
            2'd1: begin
                wdata_repl = {4{data2_in[15:0]}};
                wmask_c    = MASK_W'(8'h03 << addr_lo);
            end
            2'd2: begin
                wdata_repl = {2{data2_in[31:0]}};
                wmask_c    = MASK_W'(8'h0F << addr_lo);
            end
            default: begin
                wdata_repl = data2_in;
                wmask_c    = 8'hFF;
            end
        endcase
    end

    assign wdata_c = wdata_repl << {addr_lo, 3'b000};

    // Exception outcome for instructions that do not touch the bus
    always_comb begin
        exc_cause = CAUSE_W'(0);
        exc_tval  = XLEN'(0);
        if (cause_in != CAUSE_W'(0)) begin
            exc_cause = cause_in;
            exc_tval  = tval_in;
        end else if (load && !aligned) begin
            exc_cause = CAUSE_LD_MISALIGN;
            exc_tval  = result_in;
        end else if (store && !aligned) begin
            exc_cause = CAUSE_ST_MISALIGN;
            exc_tval  = result_in;
        end
    end

    // Load lane selection and extension, using the latched access attributes
    assign rdata_sh = dbus_rdata >> {lane_q, 3'b000};

    always_comb begin
        ld_fmt = rdata_sh;
        case (size_q)
            2'd0: ld_fmt = unsign_q ? {56'd0, rdata_sh[7:0]}
                                    : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            2'd1: ld_fmt = unsign_q ? {48'd0, rdata_sh[15:0]}
                                    : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            2'd2: ld_fmt = unsign_q ? {32'd0, rdata_sh[31:0]}
                                    : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: ld_fmt = rdata_sh;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; stall_req is raised in the detect cycle itself
    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    stall_req = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                stall_req = 1'b1;
                if (dbus_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request registers: latched at issue, held until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= XLEN'(0);
            dbus_wdata <= XLEN'(0);
            dbus_wmask <= MASK_W'(0);
            lane_q     <= 3'd0;
            size_q     <= 2'd0;
            unsign_q   <= 1'b0;
            is_store_q <= 1'b0;
            ld_data_q  <= XLEN'(0);
        end else if (state_q == IDLE && issue) begin
            dbus_req   <= 1'b1;
            dbus_we    <= store;
            dbus_addr  <= {result_in[XLEN-1:3], 3'b000};
            dbus_wdata <= store ? wdata_c : XLEN'(0);
            dbus_wmask <= store ? wmask_c : MASK_W'(0);
            lane_q     <= addr_lo;
            size_q     <= size;
            unsign_q   <= unsign;
            is_store_q <= store;
        end else if (state_q == BUS && dbus_ack) begin
            dbus_req  <= 1'b0;
            ld_data_q <= is_store_q ? XLEN'(0) : ld_fmt;
        end
    end

    // Kill flag: a flush seen mid-transaction turns the DONE advance into a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= 1'b0;
        end else if (state_q == DONE && !stall) begin
            kill_q <= 1'b0;
        end else if ((state_q == BUS || state_q == DONE) && (clear || trap_en)) begin
            kill_q <= 1'b1;
        end
    end

    // MA/WB stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out     <= XLEN'(0);
            rd_out     <= 5'd0;
            result_out <= XLEN'(0);
            cause_out  <= CAUSE_W'(0);
            tval_out   <= XLEN'(0);
        end else if (!stall) begin
            if (clear || trap_en || (state_q == DONE && kill_q)) begin
                pc_out     <= XLEN'(0);
                rd_out     <= 5'd0;
                result_out <= XLEN'(0);
                cause_out  <= CAUSE_W'(0);
                tval_out   <= XLEN'(0);
            end else if (state_q == DONE) begin
                pc_out     <= pc_in;
                rd_out     <= rd_in;
                result_out <= ld_data_q;
                cause_out  <= CAUSE_W'(0);
                tval_out   <= XLEN'(0);
            end else begin
                pc_out     <= pc_in;
                rd_out     <= rd_in;
                result_out <= store ? XLEN'(0) : result_in;
                cause_out  <= exc_cause;
                tval_out   <= exc_tval;
            end
        end
    end

endmodule
